// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state type and constants for the external memory arbiter
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } mem_state_t;

  localparam int DEFAULT_AW = 16;
  localparam int DEFAULT_DW = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with a last_grant register
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sample,
  input  logic [1:0] req,
  output logic       grant_valid,
  output logic       grant_port
);

  logic last_grant;

  always_comb begin
    grant_valid = |req;
    grant_port  = PORT0;
    if (req[0] && req[1]) begin
      grant_port = ~last_grant;
    end else if (req[1]) begin
      grant_port = PORT1;
    end
  end

  // Reset to PORT1 so that port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT1;
    end else if (sample && grant_valid) begin
      last_grant <= grant_port;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and SRAM access sequencer
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW          = DEFAULT_AW,
  parameter int DW          = DEFAULT_DW,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_dq_oe,
  output logic          mem_ce_n,
  output logic          mem_oe_n,
  output logic          mem_we_n
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("mem_arbiter: WAIT_CYCLES must be in the range 1..15");
    end
  endgenerate

  localparam logic [3:0] ACCESS_LAST = 4'(WAIT_CYCLES - 1);

  mem_state_t    state, state_nxt;
  logic [3:0]    cnt;
  logic          access_done;
  logic          grant_valid, grant_port;
  logic          port_q, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .sample      (state == IDLE),
    .req         ({req1, req0}),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  assign access_done = (state == ACCESS) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (access_done) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requester inputs are only looked at on the granting edge; the access
  // then runs entirely from these latched copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      port_q  <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == SETUP) begin
        cnt <= ACCESS_LAST;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == IDLE && grant_valid) begin
        port_q  <= grant_port;
        we_q    <= grant_port ? we1 : we0;
        addr_q  <= grant_port ? addr1 : addr0;
        wdata_q <= grant_port ? wdata1 : wdata0;
      end
      if (access_done && !we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = (state != IDLE);
    mem_ce_n  = 1'b1;
    mem_oe_n  = 1'b1;
    mem_we_n  = 1'b1;
    mem_dq_oe = 1'b0;
    case (state)
      SETUP: begin
        mem_ce_n  = 1'b0;
        mem_oe_n  = we_q;
        mem_dq_oe = we_q;
      end
      ACCESS: begin
        mem_ce_n  = 1'b0;
        mem_oe_n  = we_q;
        mem_we_n  = ~we_q;
        mem_dq_oe = we_q;
      end
      // Write strobe released but data still driven for hold time.
      HOLD: begin
        mem_ce_n  = 1'b0;
        mem_dq_oe = we_q;
        ack0      = (port_q == PORT0);
        ack1      = (port_q == PORT1);
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with SRAM model and random traffic
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int W  = 2;
  localparam int N_RANDOM = 10000;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [DW-1:0] sram [0:65535];
  int            wr_count [0:65535];
  logic          prev_we_n = 1'b1;

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_dq_oe (mem_dq_oe),
    .mem_ce_n  (mem_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM: combinational read, write while WE and CE are low.
  assign mem_rdata = sram[mem_addr];

  always @(posedge clk) begin
    if (!mem_we_n && !mem_ce_n) sram[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (prev_we_n && !mem_we_n) wr_count[mem_addr] = wr_count[mem_addr] + 1;
    prev_we_n = mem_we_n;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    tick();
    tick();
    n_cmp++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe, busy, ack0, ack1} !== 7'b1110000) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b want=1110000",
               {mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe, busy, ack0, ack1});
    end
    n_cmp++;
    if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got=%h want=0000", mem_addr); end
    n_cmp++;
    if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got=%h want=00", mem_wdata); end
    n_cmp++;
    if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h want=00", rdata); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int k, ack_cyc, n_ack, ce_low, we_low, oe_low, bad;
    n_ack = 0; ack_cyc = -1; ce_low = 0; we_low = 0; oe_low = 0; bad = 0;
    wr_count[16'h0010] = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 8'hA5;
    k = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_ce_n === 1'b0) ce_low++;
      if (mem_oe_n === 1'b0) oe_low++;
      if (mem_we_n === 1'b0) begin
        we_low++;
        if (mem_addr !== 16'h0010 || mem_wdata !== 8'hA5 || mem_dq_oe !== 1'b1) bad++;
      end
      if (ack0 === 1'b1) begin n_ack++; ack_cyc = cyc; req0 = 1'b0; end
    end
    n_cmp++;
    if (ack_cyc !== k + W + 1) begin n_fail++; $display("FAIL wr_ack_time got=%0d want=%0d", ack_cyc, k + W + 1); end
    n_cmp++;
    if (n_ack !== 1) begin n_fail++; $display("FAIL wr_ack_count got=%0d want=1", n_ack); end
    n_cmp++;
    if (ce_low !== W + 2) begin n_fail++; $display("FAIL wr_ce_cycles got=%0d want=%0d", ce_low, W + 2); end
    n_cmp++;
    if (we_low !== W) begin n_fail++; $display("FAIL wr_we_cycles got=%0d want=%0d", we_low, W); end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL wr_bus_during_we got=%0d bad cycles want=0", bad); end
    n_cmp++;
    if (oe_low !== 0) begin n_fail++; $display("FAIL wr_oe_quiet got=%0d want=0", oe_low); end
    n_cmp++;
    if (wr_count[16'h0010] !== 1 || sram[16'h0010] !== 8'hA5) begin
      n_fail++;
      $display("FAIL wr_sram got=%0d writes data=%h want=1 writes data=a5", wr_count[16'h0010], sram[16'h0010]);
    end
  endtask

  task automatic test_single_read();
    int k, ack_cyc, oe_low, we_low, dq_high, n_ack0;
    logic [DW-1:0] rd_at_ack;
    ack_cyc = -1; oe_low = 0; we_low = 0; dq_high = 0; n_ack0 = 0; rd_at_ack = 'x;
    sram[16'h0010] = 8'h3C;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010; wdata1 = 8'($urandom);
    k = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_oe_n === 1'b0) oe_low++;
      if (mem_we_n === 1'b0) we_low++;
      if (mem_dq_oe === 1'b1) dq_high++;
      if (ack0 === 1'b1) n_ack0++;
      if (ack1 === 1'b1) begin ack_cyc = cyc; rd_at_ack = rdata; req1 = 1'b0; end
    end
    n_cmp++;
    if (ack_cyc !== k + W + 1) begin n_fail++; $display("FAIL rd_ack_time got=%0d want=%0d", ack_cyc, k + W + 1); end
    n_cmp++;
    if (rd_at_ack !== 8'h3C) begin n_fail++; $display("FAIL rd_data got=%h want=3c", rd_at_ack); end
    n_cmp++;
    if (oe_low == 0) begin n_fail++; $display("FAIL rd_oe_asserted got=%0d cycles want>0", oe_low); end
    n_cmp++;
    if (we_low !== 0 || dq_high !== 0) begin
      n_fail++;
      $display("FAIL rd_no_drive got we_low=%0d dq_oe=%0d want 0 0", we_low, dq_high);
    end
    n_cmp++;
    if (n_ack0 !== 0) begin n_fail++; $display("FAIL rd_wrong_ack got=%0d want=0", n_ack0); end
    n_cmp++;
    if (rdata !== 8'h3C) begin n_fail++; $display("FAIL rd_data_hold got=%h want=3c", rdata); end
  endtask

  task automatic test_contention();
    int k, both;
    int ack_port[$];
    int ack_at[$];
    logic [DW-1:0] rd;
    both = 0; rd = 'x;
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0040; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0040; wdata1 = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    k = cyc + 1;
    for (int i = 0; i < 4 * (W + 3); i++) begin
      tick();
      if (ack0 === 1'b1 && ack1 === 1'b1) both++;
      if (ack0 === 1'b1) begin ack_port.push_back(0); ack_at.push_back(cyc); end
      if (ack1 === 1'b1) begin ack_port.push_back(1); ack_at.push_back(cyc); rd = rdata; end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2 * (W + 3)) tick();
    n_cmp++;
    if (ack_at.size() !== 4) begin n_fail++; $display("FAIL cont_ack_count got=%0d want=4", ack_at.size()); end
    for (int i = 0; i < ack_at.size() && i < 4; i++) begin
      n_cmp++;
      if (ack_port[i] !== i % 2 || ack_at[i] !== k + W + 1 + i * (W + 3)) begin
        n_fail++;
        $display("FAIL cont_grant%0d got port=%0d at=%0d want port=%0d at=%0d",
                 i, ack_port[i], ack_at[i], i % 2, k + W + 1 + i * (W + 3));
      end
    end
    n_cmp++;
    if (both !== 0) begin n_fail++; $display("FAIL cont_ack_onehot got=%0d overlaps want=0", both); end
    n_cmp++;
    if (rd !== 8'h11) begin n_fail++; $display("FAIL cont_read_after_write got=%h want=11", rd); end
  endtask

  task automatic test_back_to_back();
    int k, n;
    int ack_at[$];
    n = 0;
    for (int a = 1; a <= 3; a++) wr_count[a] = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0001; wdata0 = 8'h51;
    k = cyc + 1;
    for (int i = 0; i < 4 * (W + 3); i++) begin
      tick();
      if (ack0 === 1'b1) begin
        ack_at.push_back(cyc);
        n++;
        if (n < 3) begin
          addr0  = 16'(n + 1);
          wdata0 = 8'(8'h50 + n + 1);
        end else begin
          req0 = 1'b0;
        end
      end
    end
    n_cmp++;
    if (ack_at.size() !== 3) begin n_fail++; $display("FAIL b2b_ack_count got=%0d want=3", ack_at.size()); end
    for (int i = 0; i < ack_at.size() && i < 3; i++) begin
      n_cmp++;
      if (ack_at[i] !== k + W + 1 + i * (W + 3)) begin
        n_fail++;
        $display("FAIL b2b_ack%0d_time got=%0d want=%0d", i, ack_at[i], k + W + 1 + i * (W + 3));
      end
    end
    for (int a = 1; a <= 3; a++) begin
      n_cmp++;
      if (wr_count[a] !== 1 || sram[a] !== 8'(8'h50 + a)) begin
        n_fail++;
        $display("FAIL b2b_sram%0d got=%0d writes data=%h want=1 writes data=%h",
                 a, wr_count[a], sram[a], 8'(8'h50 + a));
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int k, first, first_at, stray;
    first = -1; first_at = -1; stray = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0077; wdata0 = 8'hEE;
    k = cyc + 1;
    repeat (3) tick();
    n_cmp++;
    if (mem_we_n !== 1'b0) begin n_fail++; $display("FAIL rma_in_access got we_n=%b want=0", mem_we_n); end
    rst = 1'b1; req0 = 1'b0;
    tick();
    n_cmp++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe, busy, ack0, ack1} !== 7'b1110000) begin
      n_fail++;
      $display("FAIL rma_abort_ctrl got=%b want=1110000",
               {mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe, busy, ack0, ack1});
    end
    n_cmp++;
    if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL rma_abort_data got addr=%h wdata=%h rdata=%h want 0000 00 00", mem_addr, mem_wdata, rdata);
    end
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
    k = cyc + 1;
    for (int i = 0; i < 2 * (W + 3); i++) begin
      tick();
      if (first < 0 && (ack0 === 1'b1 || ack1 === 1'b1)) begin
        first = (ack1 === 1'b1) ? 1 : 0;
        first_at = cyc;
      end
      if (ack0 === 1'b1) req0 = 1'b0;
      if (ack1 === 1'b1) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (W + 4) begin
      tick();
      if (ack0 === 1'b1 || ack1 === 1'b1) stray++;
    end
    n_cmp++;
    if (first !== 0 || first_at !== k + W + 1) begin
      n_fail++;
      $display("FAIL rma_first_grant got port=%0d at=%0d want port=0 at=%0d", first, first_at, k + W + 1);
    end
    n_cmp++;
    if (stray !== 0) begin n_fail++; $display("FAIL rma_stray_ack got=%0d want=0", stray); end
  endtask

  // Reference: transactions are scheduled as whole accesses. A grant at edge g
  // occupies cycles g..g+W+1 (observed at negedges), acks at g+W+1, and the
  // next arbitration edge is g+W+3.
  task automatic test_random();
    logic [1:0]    r_req, r_we;
    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_wdata [2];
    int            r_wait [2];
    logic [DW-1:0] ref_mem [8];
    logic          m_busy, m_last, m_port, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            m_g, m_next, max_wait;
    logic          exp_ce_low, exp_we_low;
    logic [1:0]    exp_ack;
    m_g = 0; max_wait = 0; m_port = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      ref_mem[a] = 8'($urandom);
      sram[16'h0020 + a] = ref_mem[a];
    end
    rst = 1'b0;
    r_req = 2'b00; r_we = 2'b00;
    for (int p = 0; p < 2; p++) begin r_addr[p] = '0; r_wdata[p] = '0; r_wait[p] = 0; end
    m_busy = 1'b0; m_last = 1'b1; m_next = cyc + 1;
    for (int i = 0; i < N_RANDOM + 60; i++) begin
      tick();
      exp_ce_low = m_busy && cyc >= m_g && cyc <= m_g + W + 1;
      exp_we_low = m_busy && m_we && cyc >= m_g + 1 && cyc <= m_g + W;
      exp_ack    = (m_busy && cyc == m_g + W + 1) ? (m_port ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++;
      if (mem_ce_n !== ~exp_ce_low) begin n_fail++; $display("FAIL rnd_ce_n cyc=%0d got=%b want=%b", cyc, mem_ce_n, ~exp_ce_low); end
      n_cmp++;
      if (mem_we_n !== ~exp_we_low) begin n_fail++; $display("FAIL rnd_we_n cyc=%0d got=%b want=%b", cyc, mem_we_n, ~exp_we_low); end
      n_cmp++;
      if (mem_dq_oe !== (exp_ce_low && m_we)) begin
        n_fail++; $display("FAIL rnd_dq_oe cyc=%0d got=%b want=%b", cyc, mem_dq_oe, exp_ce_low && m_we);
      end
      n_cmp++;
      if (mem_oe_n === 1'b0 && mem_we_n === 1'b0) begin n_fail++; $display("FAIL rnd_oe_we_both cyc=%0d got=00 want not both low", cyc); end
      n_cmp++;
      if ({ack1, ack0} !== exp_ack) begin n_fail++; $display("FAIL rnd_ack cyc=%0d got=%b want=%b", cyc, {ack1, ack0}, exp_ack); end
      if (exp_ce_low) begin
        n_cmp++;
        if (mem_addr !== m_addr || (m_we && mem_wdata !== m_wdata)) begin
          n_fail++;
          $display("FAIL rnd_bus cyc=%0d got addr=%h wdata=%h want addr=%h wdata=%h", cyc, mem_addr, mem_wdata, m_addr, m_wdata);
        end
      end
      if (exp_ack != 2'b00) begin
        if (!m_we) begin
          n_cmp++;
          if (rdata !== ref_mem[m_addr[2:0]]) begin
            n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", cyc, rdata, ref_mem[m_addr[2:0]]);
          end
        end else begin
          ref_mem[m_addr[2:0]] = m_wdata;
        end
        if (r_wait[m_port] > max_wait) max_wait = r_wait[m_port];
        r_req[m_port] = 1'b0;
        m_busy = 1'b0;
        m_next = m_g + W + 3;
      end
      for (int p = 0; p < 2; p++) begin
        if (r_req[p]) begin
          r_wait[p]++;
        end else if (i < N_RANDOM && $urandom_range(2) == 0) begin
          r_req[p]   = 1'b1;
          r_we[p]    = 1'($urandom);
          r_addr[p]  = 16'h0020 + 16'($urandom_range(7));
          r_wdata[p] = 8'($urandom);
          r_wait[p]  = 0;
        end
      end
      if (!m_busy && cyc + 1 >= m_next && r_req != 2'b00) begin
        m_port  = (r_req == 2'b11) ? ~m_last : r_req[1];
        m_last  = m_port;
        m_we    = r_we[m_port];
        m_addr  = r_addr[m_port];
        m_wdata = r_wdata[m_port];
        m_g     = cyc + 1;
        m_busy  = 1'b1;
      end
      req0 = r_req[0]; we0 = r_we[0]; addr0 = r_addr[0]; wdata0 = r_wdata[0];
      req1 = r_req[1]; we1 = r_we[1]; addr1 = r_addr[1]; wdata1 = r_wdata[1];
    end
    n_cmp++;
    if (r_req !== 2'b00) begin n_fail++; $display("FAIL rnd_starved got pending=%b want=00", r_req); end
    n_cmp++;
    if (max_wait > 2 * (W + 3)) begin n_fail++; $display("FAIL rnd_max_wait got=%0d want<=%0d", max_wait, 2 * (W + 3)); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for a single external asynchronous SRAM-style port.
- Sits between the on-chip requesters (the write pattern generator as port 0, a read-back checker as port 1) and the FPGA memory pins, in the PLL output clock domain.
- Produces CE/OE/WE strobes with a parameterised number of access wait-states.
- Returns a one-cycle acknowledge, plus read data for read accesses.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- WAIT_CYCLES, 2, length of the ACCESS phase in clk cycles (legal range 1..15).

Ports:
- clk  input  1  system clock (PLL output); all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 access request; held high until ack0.
- we0  input  1  port 0 direction: 1 = write, 0 = read.
- addr0  input  AW  port 0 address.
- wdata0  input  DW  port 0 write data.
- ack0  output  1  port 0 completion pulse, one cycle.
- req1, we1, addr1, wdata1, ack1: same definitions as port 0, for port 1.
- rdata  output  DW  read data, valid in the ack cycle of a read; shared by both ports.
- busy  output  1  high in any state other than IDLE.
- mem_addr  output  AW  external address bus.
- mem_wdata  output  DW  external write data.
- mem_rdata  input  DW  external read data.
- mem_dq_oe  output  1  1 = FPGA drives the data bus.
- mem_ce_n  output  1  chip enable, active low.
- mem_oe_n  output  1  output enable, active low.
- mem_we_n  output  1  write enable, active low.

Behaviour:
- Reset values: ack0 = ack1 = 0; busy = 0; mem_ce_n = mem_oe_n = mem_we_n = 1; mem_dq_oe = 0; mem_addr = 0; mem_wdata = 0; rdata = 0; state = IDLE; last_grant = 1, so port 0 wins the first contention.
- rst mid-access: abort immediately to the reset values; no ack is issued; the requester must re-request.
- States:
  - IDLE → SETUP → ACCESS → HOLD → IDLE.
  - IDLE: sample req0/req1 on the clock edge.
    - Only one requesting: grant it.
    - Both requesting: grant the port not equal to last_grant.
    - On grant: latch addr, wdata and we into internal registers, update last_grant, go to SETUP. Requester inputs are ignored after this edge.
  - SETUP (1 cycle):
    - mem_ce_n = 0; mem_addr driven.
    - Read: mem_oe_n = 0.
    - Write: mem_dq_oe = 1, mem_wdata driven.
  - ACCESS (WAIT_CYCLES cycles, 4-bit down-counter):
    - Strobes held.
    - Write: additionally mem_we_n = 0.
    - Read: capture mem_rdata into rdata on the last ACCESS edge.
  - HOLD (1 cycle):
    - mem_we_n = 1; mem_ce_n and mem_addr still held; mem_dq_oe still 1 for a write, giving data hold time.
    - ack of the granted port = 1.
    - Next state IDLE, where all strobes deassert.
- Latency: request sampled at edge k gives ack high during cycle k+2+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+3 cycles.
- Back-to-back accesses:
  - A req still high in the IDLE cycle after its ack is treated as a new request.
  - Requesters drop req in the ack cycle unless they want another access.
  - Under continuous contention, grants alternate 0,1,0,1.
- Strobe invariants:
  - mem_we_n is never low in SETUP or HOLD.
  - mem_oe_n and mem_we_n are never both low.
  - mem_dq_oe is never high during a read.
- rdata holds its value until the next read capture. It is not updated by writes.
- Exactly one ack asserted per grant; ack0 and ack1 are never high together.
- Out-of-range WAIT_CYCLES (0 or >15): elaboration error.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE, SETUP, ACCESS, HOLD);
  - default AW/DW constants;
  - port index constants.
- One natural sub-module, rr_arbiter2: a 2-input round-robin grant with last_grant register.
- Sequencing FSM and strobe generation stay in mem_arbiter.

Test Plan:
- Single write, WAIT_CYCLES=2: req0=1, we0=1, addr0=0x0010, wdata0=0xA5 → mem_ce_n low for 4 cycles, mem_we_n low exactly 2 cycles with mem_addr=0x0010 and mem_wdata=0xA5, ack0 pulses 4 cycles after the request edge.
- Single read: SRAM model holds 0x3C at 0x0010; req1=1, we1=0, addr1=0x0010 → mem_oe_n low, mem_we_n stays 1, mem_dq_oe stays 0, ack1 pulses with rdata=0x3C.
- Contention: req0 and req1 both asserted from reset and held → grant order 0,1,0,1; ack pulses alternate, spaced 5 cycles apart.
- Back-to-back: port 0 keeps req0 high for 3 writes to 0x0001..0x0003 → three ack0 pulses 5 cycles apart, each address written once, SRAM model matches.
- Reset mid-access: assert rst during the second ACCESS cycle of a write → next cycle all strobes at reset values and no ack; port 0 then wins the first post-reset grant.
- Assertion bench, random requests over 10k cycles: strobe invariants hold, ack0 and ack1 are one-hot or zero, and every req eventually receives an ack.
